// File: rtl/aes_seq_pkg.sv
// rtl/aes_seq_pkg.sv - shared types and constants for the AES job sequencer
// Contents: sequencer state enum, block word count, default core latencies.
package aes_seq_pkg;

    localparam int ENC_LATENCY_DEF = 33;
    localparam int DEC_LATENCY_DEF = 45;
    localparam int CNT_W_DEF       = 6;
    localparam int WORDS_PER_BLOCK = 4;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_LATCH,
        S_CORE_RST,
        S_RUN,
        S_CAPTURE,
        S_DRAIN,
        S_DONE
    } seq_state_t;

endpackage

// File: rtl/aes_tx_serializer.sv
// rtl/aes_tx_serializer.sv - splits a 128-bit result into four 32-bit TX FIFO writes
// Ports:
//   clk, rst      : clock, synchronous active-high reset
//   load          : capture block and restart at word 0
//   block         : 128-bit result to serialize
//   tx_fifo_full  : TX FIFO full flag; stalls the current word
//   tx_write_en   : TX FIFO write strobe
//   tx_data_in    : TX FIFO write data, MSB word first
//   last_written  : high on the cycle the final word is written
module aes_tx_serializer
    import aes_seq_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [127:0] block,
    input  logic         tx_fifo_full,
    output logic         tx_write_en,
    output logic [31:0]  tx_data_in,
    output logic         last_written
);

    logic [127:0] result;
    logic [1:0]   idx;
    logic         active;

    always_ff @(posedge clk) begin
        if (rst) begin
            result <= '0;
            idx    <= '0;
            active <= 1'b0;
        end else if (load) begin
            result <= block;
            idx    <= '0;
            active <= 1'b1;
        end else if (tx_write_en) begin
            // Index only moves on an accepted write, so a full FIFO holds the word.
            idx <= idx + 2'd1;
            if (idx == 2'(WORDS_PER_BLOCK - 1))
                active <= 1'b0;
        end
    end

    // Combinational so the strobe reacts to full in the same cycle.
    assign tx_write_en  = active & ~tx_fifo_full;
    assign last_written = tx_write_en && (idx == 2'(WORDS_PER_BLOCK - 1));

    always_comb begin
        tx_data_in = result[127:96];
        case (idx)
            2'd0: tx_data_in = result[127:96];
            2'd1: tx_data_in = result[95:64];
            2'd2: tx_data_in = result[63:32];
            2'd3: tx_data_in = result[31:0];
            default: tx_data_in = result[127:96];
        endcase
    end

endmodule

// File: rtl/aes_job_sequencer.sv
// rtl/aes_job_sequencer.sv - moves packets RX FIFO -> AES core -> TX FIFO, one job at a time
// Ports:
//   clk, rst                 : clock, synchronous active-high reset
//   run_en                   : allow new jobs to start
//   mode_in, key_in          : job mode (1 = encrypt) and key, sampled in LATCH
//   rx_fifo_empty/read_en    : RX FIFO status and pop strobe
//   rx_data_out              : RX FIFO data, valid the cycle after the pop
//   aes_restart              : core restart pulse
//   aes_encrypt_enable, aes_data_in, aes_key : held core inputs
//   aes_data_out             : core result
//   tx_fifo_full/write_en/data_in : TX FIFO interface
//   busy, job_done, job_count : status
module aes_job_sequencer
    import aes_seq_pkg::*;
#(
    parameter int ENC_LATENCY = ENC_LATENCY_DEF,
    parameter int DEC_LATENCY = DEC_LATENCY_DEF,
    parameter int CNT_W       = CNT_W_DEF
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         run_en,
    input  logic         mode_in,
    input  logic [127:0] key_in,
    input  logic         rx_fifo_empty,
    output logic         rx_read_en,
    input  logic [127:0] rx_data_out,
    output logic         aes_restart,
    output logic         aes_encrypt_enable,
    output logic [127:0] aes_data_in,
    output logic [127:0] aes_key,
    input  logic [127:0] aes_data_out,
    input  logic         tx_fifo_full,
    output logic         tx_write_en,
    output logic [31:0]  tx_data_in,
    output logic         busy,
    output logic         job_done,
    output logic [15:0]  job_count
);

    seq_state_t       state;
    logic [CNT_W-1:0] cnt;
    logic             last_written;

    always_ff @(posedge clk) begin
        if (rst) begin
            state              <= S_IDLE;
            cnt                <= '0;
            rx_read_en         <= 1'b0;
            aes_restart        <= 1'b0;
            aes_encrypt_enable <= 1'b0;
            aes_data_in        <= '0;
            aes_key            <= '0;
            busy               <= 1'b0;
            job_done           <= 1'b0;
            job_count          <= '0;
        end else begin
            // Strobes are registered alongside the state they belong to.
            rx_read_en  <= 1'b0;
            aes_restart <= 1'b0;
            job_done    <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (run_en && !rx_fifo_empty) begin
                        state      <= S_FETCH;
                        rx_read_en <= 1'b1;
                        busy       <= 1'b1;
                    end
                end
                S_FETCH: state <= S_LATCH;
                S_LATCH: begin
                    aes_data_in        <= rx_data_out;
                    aes_key            <= key_in;
                    aes_encrypt_enable <= mode_in;
                    aes_restart        <= 1'b1;
                    state              <= S_CORE_RST;
                end
                S_CORE_RST: begin
                    // Count LATENCY-1 down to 0 so RUN spans exactly LATENCY cycles.
                    cnt   <= aes_encrypt_enable ? CNT_W'(ENC_LATENCY - 1)
                                                : CNT_W'(DEC_LATENCY - 1);
                    state <= S_RUN;
                end
                S_RUN: begin
                    if (cnt == '0)
                        state <= S_CAPTURE;
                    else
                        cnt <= cnt - 1'b1;
                end
                S_CAPTURE: state <= S_DRAIN;
                S_DRAIN: begin
                    if (last_written) begin
                        state     <= S_DONE;
                        job_done  <= 1'b1;
                        job_count <= job_count + 16'd1;
                    end
                end
                S_DONE: begin
                    if (run_en && !rx_fifo_empty) begin
                        state      <= S_FETCH;
                        rx_read_en <= 1'b1;
                    end else begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    aes_tx_serializer u_ser (
        .clk          (clk),
        .rst          (rst),
        .load         (state == S_CAPTURE),
        .block        (aes_data_out),
        .tx_fifo_full (tx_fifo_full),
        .tx_write_en  (tx_write_en),
        .tx_data_in   (tx_data_in),
        .last_written (last_written)
    );

endmodule

// File: tb/tb_aes_job_sequencer.sv
// tb/tb_aes_job_sequencer.sv - self-checking bench for aes_job_sequencer
`timescale 1ns/1ps
module tb_aes_job_sequencer;
    import aes_seq_pkg::*;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         run_en = 1'b0;
    logic         mode_in = 1'b0;
    logic [127:0] key_in = '0;
    logic         rx_fifo_empty = 1'b1;
    logic         rx_read_en;
    logic [127:0] rx_data_out = '0;
    logic         aes_restart;
    logic         aes_encrypt_enable;
    logic [127:0] aes_data_in;
    logic [127:0] aes_key;
    logic [127:0] aes_data_out;
    logic         tx_fifo_full = 1'b0;
    logic         tx_write_en;
    logic [31:0]  tx_data_in;
    logic         busy;
    logic         job_done;
    logic [15:0]  job_count;

    always #5 clk = ~clk;

    aes_job_sequencer dut (
        .clk(clk), .rst(rst), .run_en(run_en), .mode_in(mode_in), .key_in(key_in),
        .rx_fifo_empty(rx_fifo_empty), .rx_read_en(rx_read_en), .rx_data_out(rx_data_out),
        .aes_restart(aes_restart), .aes_encrypt_enable(aes_encrypt_enable),
        .aes_data_in(aes_data_in), .aes_key(aes_key), .aes_data_out(aes_data_out),
        .tx_fifo_full(tx_fifo_full), .tx_write_en(tx_write_en), .tx_data_in(tx_data_in),
        .busy(busy), .job_done(job_done), .job_count(job_count)
    );

    // Known-answer vectors: inputs, core result and FETCH-to-job_done latency.
    typedef struct {
        logic [127:0] key;
        logic         mode;
        logic [127:0] pkt;
        logic [127:0] res;
        int           lat;
    } vec_t;
    localparam int NVEC = 2;
    vec_t vt [NVEC];

    int n_cmp = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Stand-in for the AES core: known vectors answer exactly, anything else gets a keyed mix.
    function automatic logic [127:0] core_fn(input logic [127:0] d, input logic [127:0] k, input logic m);
        for (int i = 0; i < NVEC; i++)
            if (vt[i].pkt == d && vt[i].key == k && vt[i].mode == m)
                return vt[i].res;
        return ((d << 7) | (d >> 121)) ^ k ^ {4{m ? 32'hA5A50F0F : 32'h5A5AF0F0}};
    endfunction

    // Core model: result valid only once LATENCY cycles have passed since restart
    // and only while the inputs stay as they were at restart.
    logic [127:0] snap_d = '0, snap_k = '0;
    logic         snap_m = 1'b0, core_armed = 1'b0;
    int           core_cnt = 0;
    logic         core_ok;

    always @(posedge clk) begin
        if (rst) begin
            core_armed <= 1'b0;
        end else if (aes_restart) begin
            core_armed <= 1'b1;
            core_cnt   <= 0;
            snap_d     <= aes_data_in;
            snap_k     <= aes_key;
            snap_m     <= aes_encrypt_enable;
        end else if (core_cnt < 1000) begin
            core_cnt <= core_cnt + 1;
        end
    end

    assign core_ok = core_armed && (core_cnt >= (snap_m ? ENC_LATENCY_DEF : DEC_LATENCY_DEF))
                     && snap_d == aes_data_in && snap_k == aes_key && snap_m == aes_encrypt_enable;
    assign aes_data_out = core_ok ? core_fn(snap_d, snap_k, snap_m) : {4{32'hDEADBEEF}};

    // RX FIFO model: pushes from the stimulus, pops on rx_read_en, data the next cycle.
    logic [127:0] rx_mem [0:511];
    int rx_wr = 0;
    int rx_rd = 0;

    always @(posedge clk) begin
        if (rx_read_en && rx_rd < rx_wr) begin
            rx_data_out   <= rx_mem[rx_rd];
            rx_rd         <= rx_rd + 1;
            rx_fifo_empty <= (rx_rd + 1 >= rx_wr);
        end else begin
            rx_fifo_empty <= (rx_rd >= rx_wr);
        end
    end

    // Reference: each fetched packet, with the key/mode seen in the cycle after the
    // pop, yields four expected TX words MSB first; every write must match in order.
    logic [31:0]  exp_q [$];
    logic [31:0]  tx_log [$];
    logic [127:0] latch_pkt = '0;
    logic [127:0] ref_r;
    logic [15:0]  model_jobs = '0;
    bit latch_pend = 0, jc_pend = 0;
    int cyc = 0, n_fetch = 0, n_done = 0, n_tx = 0;
    int last_fetch = 0, last_done = -100, done_lat = 0, gap = 0;

    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            exp_q.delete();
            latch_pend = 0;
            jc_pend    = 0;
            model_jobs = '0;
        end else begin
            if (jc_pend) begin
                check("job_count", 128'(job_count), 128'(model_jobs));
                jc_pend = 0;
            end
            if (latch_pend) begin
                ref_r = core_fn(latch_pkt, key_in, mode_in);
                for (int w = 0; w < WORDS_PER_BLOCK; w++)
                    exp_q.push_back(ref_r[127 - 32*w -: 32]);
                latch_pend = 0;
            end
            if (rx_read_en) begin
                check("rd_while_empty", 128'(rx_fifo_empty), 128'(0));
                n_fetch++;
                gap        = cyc - last_done;
                last_fetch = cyc;
                latch_pkt  = rx_mem[rx_rd];
                latch_pend = 1;
            end
            if (tx_write_en) begin
                check("wr_while_full", 128'(tx_fifo_full), 128'(0));
                if (!tx_fifo_full) begin
                    if (exp_q.size() == 0)
                        check("unexpected_tx", 128'(tx_data_in), 128'(0) - 128'(1));
                    else
                        check("tx_word", 128'(tx_data_in), 128'(exp_q.pop_front()));
                    tx_log.push_back(tx_data_in);
                    n_tx++;
                end
            end
            if (job_done) begin
                check_int("words_left_at_done", exp_q.size(), 0);
                n_done++;
                done_lat   = cyc - last_fetch;
                last_done  = cyc;
                model_jobs = model_jobs + 16'd1;
                jc_pend    = 1;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push(input logic [127:0] p);
        rx_mem[rx_wr] = p;
        rx_wr++;
    endtask

    task automatic wait_done(input int target, input int budget, input string name);
        int t = 0;
        while (n_done < target && t < budget) begin
            tick(1);
            t++;
        end
        check_int({name, "_done_seen"}, n_done >= target ? 1 : 0, 1);
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_strobes"}, 128'({rx_read_en, aes_restart, aes_encrypt_enable,
                                        tx_write_en, busy, job_done}), 128'(0));
        check({tag, "_aes_data_in"}, aes_data_in, 128'(0));
        check({tag, "_aes_key"}, aes_key, 128'(0));
        check({tag, "_tx_data_in"}, 128'(tx_data_in), 128'(0));
        check({tag, "_job_count"}, 128'(job_count), 128'(0));
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base, t, nf;
        logic [127:0] p, r;

        vt[0] = '{128'h5E74E7BA66B0C7CC1B7697B3F9F51527, 1'b0,
                  128'hdeb0f81341f3503a7cd01e2bc7cdd556,
                  128'h7D8AE0F7CFA0A6CB09FB5D05A8EC586D, 53};
        vt[1] = '{128'h5E74E7BA66B0C7CC1B7697B3F9F51527, 1'b1,
                  128'h7D8AE0F7CFA0A6CB09FB5D05A8EC586D,
                  128'hdeb0f81341f3503a7cd01e2bc7cdd556, 41};

        // Power-on reset.
        rst = 1'b1;
        tick(3);
        check_idle_outputs("por");
        rst = 1'b0;
        tick(2);

        // Known-answer jobs, one at a time.
        for (int i = 0; i < NVEC; i++) begin
            key_in  = vt[i].key;
            mode_in = vt[i].mode;
            push(vt[i].pkt);
            run_en = 1'b1;
            wait_done(n_done + 1, 300, "vec");
            check_int("vec_latency", done_lat, vt[i].lat);
            for (int w = 0; w < 4; w++)
                check("vec_word", 128'(tx_log[tx_log.size() - 4 + w]), 128'(vt[i].res[127 - 32*w -: 32]));
            tick(1);
            check("vec_job_count", 128'(job_count), 128'(i + 1));
        end
        tick(3);
        check("idle_busy", 128'(busy), 128'(0));

        // Back-to-back: second FETCH immediately follows DONE.
        key_in  = 128'h33DE20E331BA5A525AB7C2495A767B5A;
        mode_in = 1'b0;
        push(128'h67928dd5470d4a11f0ea4ae7d49b2dd4);
        push({$urandom, $urandom, $urandom, $urandom});
        base = n_done;
        wait_done(base + 2, 400, "b2b");
        check_int("b2b_fetch_gap", gap, 1);
        tick(1);
        check("b2b_job_count", 128'(job_count), 128'(4));

        // Backpressure after the second word.
        key_in  = 128'h0123456789ABCDEF0F1E2D3C4B5A6978;
        mode_in = 1'b1;
        p = 128'hCAFEF00D_11223344_55667788_99AABBCC;
        r = core_fn(p, key_in, mode_in);
        push(p);
        base = n_tx;
        t = 0;
        while (n_tx < base + 2 && t < 300) begin
            tick(1);
            t++;
        end
        check_int("bp_reached_word2", n_tx, base + 2);
        tx_fifo_full = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick(1);
            check("bp_hold_word", 128'(tx_data_in), 128'(r[63:32]));
            check("bp_no_write", 128'(tx_write_en), 128'(0));
        end
        tx_fifo_full = 1'b0;
        wait_done(n_done + 1, 100, "bp");
        for (int w = 0; w < 4; w++)
            check("bp_word", 128'(tx_log[tx_log.size() - 4 + w]), 128'(r[127 - 32*w -: 32]));
        tick(3);

        // Gating: no fetch while run_en is low.
        run_en = 1'b0;
        push({$urandom, $urandom, $urandom, $urandom});
        nf = n_fetch;
        tick(20);
        check_int("gate_no_fetch", n_fetch, nf);
        run_en = 1'b1;
        t = 0;
        while (n_fetch == nf && t < 20) begin
            tick(1);
            t++;
        end
        check_int("gate_fetch_after_enable", n_fetch, nf + 1);
        tick(10);
        run_en = 1'b0;
        push({$urandom, $urandom, $urandom, $urandom});
        wait_done(n_done + 1, 200, "gate");
        tick(3);
        check("gate_idle_busy", 128'(busy), 128'(0));
        tick(20);
        check_int("gate_no_refetch", n_fetch, nf + 1);

        // Reset mid-RUN abandons the job.
        run_en = 1'b1;
        t = 0;
        while (n_fetch == nf + 1 && t < 20) begin
            tick(1);
            t++;
        end
        tick(15);
        run_en = 1'b0;
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        check_idle_outputs("midrun_rst");
        base = n_tx;
        tick(60);
        check_int("rst_no_tx", n_tx, base);
        check("rst_job_count", 128'(job_count), 128'(0));
        check("rst_busy", 128'(busy), 128'(0));

        // Randomized traffic: key/mode churn every cycle, random full and run_en.
        base = n_done;
        for (int c = 0; c < 2500; c++) begin
            tick(1);
            if ($urandom_range(0, 19) == 0 && rx_wr < 500)
                push({$urandom, $urandom, $urandom, $urandom});
            key_in       = {$urandom, $urandom, $urandom, $urandom};
            mode_in      = $urandom_range(0, 1) == 1;
            tx_fifo_full = $urandom_range(0, 3) == 0;
            run_en       = $urandom_range(0, 15) != 0;
        end
        tx_fifo_full = 1'b0;
        run_en       = 1'b1;
        t = 0;
        while (!(rx_rd == rx_wr && !busy) && t < 5000) begin
            tick(1);
            t++;
        end
        check_int("rand_settled", (rx_rd == rx_wr && !busy) ? 1 : 0, 1);
        tick(3);
        check_int("rand_words_left", exp_q.size(), 0);
        check("rand_job_count", 128'(job_count), 128'(model_jobs));
        check_int("rand_jobs_ran", (n_done - base) > 10 ? 1 : 0, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/aes_job_sequencer.md
Name: aes_job_sequencer

Overview:
- Autonomous job controller between the RX FIFO (128-bit read side), the AES top-level block and the TX FIFO (32-bit write side).
- Pops one 128-bit packet and drives it, with key and mode, into the AES core.
- Holds the core inputs stable for the core's fixed encrypt or decrypt latency, then captures the result.
- Serializes the result into the TX FIFO as four 32-bit words, MSB word first; repeats while enabled and the RX FIFO is non-empty.

Parameters:
ENC_LATENCY, 33, cycles from core restart release to valid encrypted output.
DEC_LATENCY, 45, cycles from core restart release to valid decrypted output.
CNT_W, 6, width of the latency down-counter; must hold max(ENC_LATENCY, DEC_LATENCY).

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous, active-high reset
run_en  in  1  1 = start new jobs; 0 = finish current job, then idle
mode_in  in  1  1 = encrypt, 0 = decrypt; sampled in LATCH
key_in  in  128  cipher key; sampled in LATCH
rx_fifo_empty  in  1  RX FIFO empty flag
rx_read_en  out  1  one-cycle pop strobe to RX FIFO
rx_data_out  in  128  RX FIFO read data, valid the cycle after rx_read_en
aes_restart  out  1  active-high restart to AES core (top level inverts it onto the core's active-low reset)
aes_encrypt_enable  out  1  mode to core
aes_data_in  out  128  packet to core
aes_key  out  128  key to core
aes_data_out  in  128  core result
tx_fifo_full  in  1  TX FIFO full flag
tx_write_en  out  1  TX FIFO write strobe
tx_data_in  out  32  TX FIFO write data
busy  out  1  high in every state except IDLE
job_done  out  1  one-cycle pulse when the 4th word is written
job_count  out  16  completed jobs, wraps 0xFFFF -> 0x0000

Behaviour:
- Reset (rst=1 at a clk edge):
  - State goes to IDLE.
  - All outputs are 0 and all data registers are 0, including job_count, aes_data_in and aes_key.
  - aes_restart is 0 after reset.
  - Reset mid-job abandons the job; an already-popped packet is lost, and no partial TX words follow.
- IDLE: if run_en=1 and rx_fifo_empty=0, go to FETCH; otherwise stay.
- FETCH (1 cycle): rx_read_en=1; go to LATCH.
- LATCH (1 cycle): register rx_data_out->aes_data_in, key_in->aes_key, mode_in->aes_encrypt_enable. These hold until the next LATCH or reset. Go to CORE_RST.
- CORE_RST (1 cycle): aes_restart=1; load counter with ENC_LATENCY-1 or DEC_LATENCY-1 per the latched mode; go to RUN.
- RUN: decrement counter each cycle; at 0 go to CAPTURE. RUN lasts exactly LATENCY cycles.
- CAPTURE (1 cycle): register aes_data_out into result; clear word index; go to DRAIN.
- DRAIN:
  - tx_data_in = result word[idx], with idx0 = bits 127:96 and idx3 = bits 31:0.
  - tx_write_en = !tx_fifo_full.
  - Index advances only on a cycle where a write occurs.
  - While full: hold idx, tx_write_en=0, no timeout.
  - The write of idx3 goes to DONE.
- DONE (1 cycle): job_done=1, job_count+1; go to FETCH if run_en and !rx_fifo_empty, else IDLE.
- rx_read_en is never asserted while rx_fifo_empty=1. Empty is checked only in IDLE/DONE, and the packet pops in the next cycle, so nothing can drain it in between.
- run_en falling mid-job does not abort the job; it only prevents the next fetch.
- mode_in/key_in changes outside LATCH have no effect on the running job.
- Throughput per job, with TX never full: 1 FETCH + 1 LATCH + 1 CORE_RST + LATENCY + 1 CAPTURE + 4 DRAIN + 1 DONE.
- Latency from FETCH to job_done: 8+LATENCY cycles (41 encrypt, 53 decrypt at defaults).

Decomposition:
- Package aes_seq_pkg holds:
  - state enum (IDLE, FETCH, LATCH, CORE_RST, RUN, CAPTURE, DRAIN, DONE)
  - WORDS_PER_BLOCK=4
  - default ENC_LATENCY/DEC_LATENCY constants, shared with the bench
- One sub-module, aes_tx_serializer, is natural:
  - load strobe + 128-bit word in
  - 2-bit index
  - full-aware write strobe
  - last-word-written pulse

Test Plan:
1. Reset: assert rst 2 cycles mid-RUN -> next cycle all outputs 0, state IDLE, no tx_write_en afterwards, job_count=0.
2. Decrypt: key 5E74E7BA66B0C7CC1B7697B3F9F51527, mode 0, RX packet deb0f81341f3503a7cd01e2bc7cdd556 -> TX words 7D8AE0F7, CFA0A6CB, 09FB5D05, A8EC586D in order; job_done exactly 53 cycles after rx_read_en; job_count=1.
3. Encrypt: same key, mode 1, packet 7D8AE0F7CFA0A6CB09FB5D05A8EC586D -> TX words deb0f813, 41f3503a, 7cd01e2b, c7cdd556; job_done 41 cycles after rx_read_en.
4. Back-to-back: two packets queued, key 33DE20E331BA5A525AB7C2495A767B5A:
   - decrypt 67928dd5470d4a11f0ea4ae7d49b2dd4 -> E6FEBF30..D36D0D4F
   - FETCH for job 2 occurs the cycle after DONE with no IDLE cycle between; job_count=2
5. Backpressure: hold tx_fifo_full=1 for 5 cycles after the 2nd word -> no tx_write_en during full, tx_data_in holds word 3, and the remaining words arrive in order once full drops.
6. Gating: run_en=0 with a non-empty RX FIFO -> no rx_read_en for 20 cycles. Dropping run_en during RUN -> current job completes, then IDLE with busy=0.
